fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Parametrised multi-slot instruction queue between IF and ID of the pipelined MIPS core.
//  Accepts up to FETCH_W instructions per cycle from IF and presents up to ISSUE_W to ID.
//  Supports flush on taken branch and FREEZE stall.
//  Successor to the fixed dual-fetch Instr1/Instr2 path: generalised width and depth, with decoupled buffering.
// PARAMETERS
//  FETCH_W  2  instructions accepted per cycle (>=1)
//  ISSUE_W  2  instructions presented per cycle (>=1, <=DEPTH)
//  DEPTH    8  queue entries; power of two, >= FETCH_W
// PORTS
//  CLK          in   1            clock, rising edge
//  RESET        in   1            asynchronous, active-low reset
//  flush        in   1            discard all entries (taken branch / SYS)
//  FREEZE       in   1            hold issue side; no pop this cycle
//  fetch_count  in   clog2(FETCH_W+1)  number of valid fetch slots, packed from slot 0
//  fetch_pc     in   32           PC of slot 0; slot i PC = fetch_pc + 4*i
//  fetch_instr  in   32*FETCH_W   slot i at [32*i +: 32]
//  fetch_ready  out  1            queue can take FETCH_W entries this cycle
//  issue_valid  out  ISSUE_W      thermometer code; bit i = entry (head+i) present
//  issue_pc     out  32*ISSUE_W   PC per issue slot
//  issue_instr  out  32*ISSUE_W   instruction per issue slot; 0x00000000 (NOP) when slot invalid
//  issue_take   in   clog2(ISSUE_W+1)  entries ID consumes this cycle
//  occupancy    out  clog2(DEPTH+1)    current entry count
// BEHAVIOUR
//  - Reset (RESET=0, async): head=tail=0, occupancy=0, issue_valid=0, issue_instr/pc=0, fetch_ready=1.
//  - fetch_ready = (DEPTH - occupancy) >= FETCH_W, from registered occupancy only (pop-independent).
//  - Push is all-or-nothing: fetch_count>0 while fetch_ready=0 is ignored entirely. IF must hold its slots.
//  - Push writes fetch_count entries at tail..tail+n-1 (mod DEPTH). tail advances by n.
//  - Pop: eff_take = FREEZE ? 0 : min(issue_take, popcount(issue_valid)). head advances by eff_take.
//    issue_take > valid count is a protocol error: flagged by assertion, clamped in RTL.
//  - occupancy_next = occupancy + push_n - eff_take. Push and pop in the same cycle are both honoured.
//  - Min latency without bypass is 1 cycle: an entry pushed at edge N is visible on issue at N+1.
//  - issue slot i shows entry (head+i) mod DEPTH when i < occupancy; otherwise valid=0, instr=NOP, pc=0.
//  - Pointers are log2(DEPTH) bits and wrap naturally. Full is resolved by occupancy, not pointer compare.
//  - flush=1: at next edge head=tail=0 and occupancy=0. Same-cycle push and pop are discarded.
//    flush overrides FREEZE.
//  - FREEZE does not block push. The queue fills up to DEPTH while frozen.
// CONFIGURATION
//  FETCH_QUEUE_BYPASS_EN defined: when occupancy==0 and flush=0, incoming fetch slots drive issue outputs
//    combinationally in the same cycle. Bypassed entries taken by ID (eff_take) are not written. The rest are
//    enqueued at tail=head. FREEZE=1 forces eff_take=0, so everything is enqueued.
//  Not defined: no combinational path fetch->issue; 1-cycle minimum latency.
// STRUCTURE
//  Shared package mips_pkg: INSTR_W=32, PC_STEP=4, NOP_INSTR=32'h0, typedef fq_entry_t {pc[31:0], instr[31:0]}.
//  Sub-module fetch_queue_ram: DEPTH x fq_entry_t register array.
//    FETCH_W write ports at tail+i and ISSUE_W read ports at head+i, with modular indexing.
//  Top holds pointers, occupancy, ready/valid logic and the bypass mux.
// TESTING
//  1 Reset mid-fill: 5 entries queued, RESET low -> occupancy=0, issue_valid=00, fetch_ready=1 immediately.
//  2 Fill: fetch_count=2 each cycle, take=0, pc=0x400 -> after 3 pushes occupancy=6, fetch_ready=1.
//    After the 4th push, occupancy=8 and fetch_ready=0. A 5th push is ignored.
//  3 Simultaneous: occupancy=8, take=2 and push 2 -> fetch_ready=0, so the push is dropped; occupancy=6 next cycle.
//    Next cycle push 2, take 2 -> occupancy stays 6. issue_pc order is monotonic by +4.
//  4 Wrap: 12 pushes/pops of 1 entry starting at pc=0x1000 -> issue_pc sequence 0x1000..0x102C with no gap across the index 7->0 wrap.
//  5 Flush: occupancy=4 with flush=1, push 2, take 1 in the same cycle -> occupancy=0, issue_valid=00 next cycle.
//  6 FREEZE=1 with take=2 and occupancy=3 -> head unchanged and occupancy=3.
//    With FETCH_QUEUE_BYPASS_EN, an empty queue, push of 2 at 0x200 and take=1 -> same-cycle issue_pc[0]=0x200; occupancy=1 next cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core types: instruction width, PC stride, NOP encoding and the fetch-queue entry.
package mips_pkg;
  localparam int          INSTR_W   = 32;
  localparam logic [31:0] PC_STEP   = 32'd4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;
endpackage

// File: rtl/fetch_queue_ram.sv
// DEPTH-entry register array with FETCH_W write ports at wr_base+i and ISSUE_W read ports at rd_base+i.
// Indices wrap modulo DEPTH through the natural overflow of the pointer-width sum.
module fetch_queue_ram
  import mips_pkg::*;
#(
  parameter int FETCH_W = 2,
  parameter int ISSUE_W = 2,
  parameter int DEPTH   = 8,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [FETCH_W-1:0] wr_en,
  input  logic [PTR_W-1:0] wr_base,
  input  fq_entry_t        wr_ent [FETCH_W],
  input  logic [PTR_W-1:0] rd_base,
  output fq_entry_t        rd_ent [ISSUE_W]
);
  fq_entry_t mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else begin
      for (int i = 0; i < FETCH_W; i++) begin
        if (wr_en[i]) mem[wr_base + PTR_W'(i)] <= wr_ent[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < ISSUE_W; i++) rd_ent[i] = mem[rd_base + PTR_W'(i)];
  end
endmodule

// File: rtl/fetch_queue.sv
// IF->ID instruction queue: FETCH_W-wide all-or-nothing push, ISSUE_W-wide issue, flush and FREEZE.
// Define FETCH_QUEUE_BYPASS_EN to steer fetch slots straight to issue when the queue is empty.
module fetch_queue
  import mips_pkg::*;
#(
  parameter int FETCH_W = 2,
  parameter int ISSUE_W = 2,
  parameter int DEPTH   = 8,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CW     = $clog2(FETCH_W + 1),
  localparam int TW     = $clog2(ISSUE_W + 1),
  localparam int OW     = $clog2(DEPTH + 1)
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         flush,
  input  logic                         FREEZE,
  input  logic [CW-1:0]                fetch_count,
  input  logic [31:0]                  fetch_pc,
  input  logic [INSTR_W*FETCH_W-1:0]   fetch_instr,
  output logic                         fetch_ready,
  output logic [ISSUE_W-1:0]           issue_valid,
  output logic [32*ISSUE_W-1:0]        issue_pc,
  output logic [INSTR_W*ISSUE_W-1:0]   issue_instr,
  input  logic [TW-1:0]                issue_take,
  output logic [OW-1:0]                occupancy
);
  localparam logic [OW-1:0] READY_MAX = OW'(DEPTH - FETCH_W);
  localparam logic [OW-1:0] FETCH_MAX = OW'(FETCH_W);
  localparam logic [OW-1:0] ISSUE_MAX = OW'(ISSUE_W);

  logic [PTR_W-1:0] head, tail;
  fq_entry_t        fetch_ent [FETCH_W];
  fq_entry_t        wr_ent [FETCH_W];
  fq_entry_t        rd_ent [ISSUE_W];
  logic [FETCH_W-1:0] wr_en;
  logic [OW-1:0]    req_n, push_n, avail, eff_take, skip, wr_n;
  logic             bypass;

  assign fetch_ready = (occupancy <= READY_MAX);
  assign req_n       = (OW'(fetch_count) > FETCH_MAX) ? FETCH_MAX : OW'(fetch_count);
  assign push_n      = fetch_ready ? req_n : '0;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = (occupancy == '0) && !flush;
`else
  assign bypass = 1'b0;
`endif

  // While bypassing, the entries ID takes this cycle are never written.
  assign avail    = bypass ? ((push_n < ISSUE_MAX) ? push_n : ISSUE_MAX)
                           : ((occupancy < ISSUE_MAX) ? occupancy : ISSUE_MAX);
  assign eff_take = FREEZE ? '0 : ((OW'(issue_take) < avail) ? OW'(issue_take) : avail);
  assign skip     = bypass ? eff_take : '0;
  assign wr_n     = push_n - skip;

  always_comb begin
    for (int j = 0; j < FETCH_W; j++) begin
      fetch_ent[j].pc    = fetch_pc + PC_STEP * 32'(j);
      fetch_ent[j].instr = fetch_instr[INSTR_W*j +: INSTR_W];
    end
  end

  always_comb begin
    for (int i = 0; i < FETCH_W; i++) begin
      wr_ent[i] = '0;
      wr_en[i]  = !flush && (OW'(i) < wr_n);
      for (int j = 0; j < FETCH_W; j++) begin
        if (OW'(j) == OW'(i) + skip) wr_ent[i] = fetch_ent[j];
      end
    end
  end

  fetch_queue_ram #(.FETCH_W(FETCH_W), .ISSUE_W(ISSUE_W), .DEPTH(DEPTH)) u_ram (
    .clk     (CLK),
    .rst_n   (RESET),
    .wr_en   (wr_en),
    .wr_base (tail),
    .wr_ent  (wr_ent),
    .rd_base (head),
    .rd_ent  (rd_ent)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
    end else if (flush) begin
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
    end else begin
      head      <= head + PTR_W'(eff_take - skip);
      tail      <= tail + PTR_W'(wr_n);
      occupancy <= occupancy + wr_n - (eff_take - skip);
    end
  end

  always_comb begin
    fq_entry_t sel;
    logic      vld;
    for (int i = 0; i < ISSUE_W; i++) begin
      sel = rd_ent[i];
      vld = (OW'(i) < occupancy);
      if (bypass) begin
        sel = '0;
        vld = (OW'(i) < push_n);
        for (int j = 0; j < FETCH_W; j++) begin
          if (j == i) sel = fetch_ent[j];
        end
      end
      issue_valid[i]                  = vld;
      issue_pc[32*i +: 32]            = vld ? sel.pc : 32'h0;
      issue_instr[INSTR_W*i +: INSTR_W] = vld ? sel.instr : NOP_INSTR;
    end
  end

  // ID must never ask for more entries than are presented; the RTL clamps regardless.
  assert property (@(posedge CLK) disable iff (!RESET)
    (FREEZE || flush || (OW'(issue_take) <= avail)));
endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue (FETCH_W=2, ISSUE_W=2, DEPTH=8).
module tb_fetch_queue;
  import mips_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        flush = 1'b0;
  logic        FREEZE = 1'b0;
  logic [1:0]  fetch_count = '0;
  logic [31:0] fetch_pc = '0;
  logic [63:0] fetch_instr = '0;
  logic        fetch_ready;
  logic [1:0]  issue_valid;
  logic [63:0] issue_pc;
  logic [63:0] issue_instr;
  logic [1:0]  issue_take = '0;
  logic [3:0]  occupancy;

  int checks = 0;
  int errors = 0;
  fq_entry_t sb[$];

  fetch_queue #(.FETCH_W(2), .ISSUE_W(2), .DEPTH(8)) dut (
    .CLK(CLK), .RESET(RESET), .flush(flush), .FREEZE(FREEZE),
    .fetch_count(fetch_count), .fetch_pc(fetch_pc), .fetch_instr(fetch_instr),
    .fetch_ready(fetch_ready), .issue_valid(issue_valid), .issue_pc(issue_pc),
    .issue_instr(issue_instr), .issue_take(issue_take), .occupancy(occupancy)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mk(input logic [31:0] pc);
    return {16'hC0DE, pc[15:0]};
  endfunction

  task automatic drive(input int cnt, input logic [31:0] pc, input int take, input logic frz, input logic fl);
    @(negedge CLK);
    fetch_count = 2'(cnt);
    fetch_pc    = pc;
    fetch_instr = {mk(pc + 32'd4), mk(pc)};
    issue_take  = 2'(take);
    FREEZE      = frz;
    flush       = fl;
    #1;
  endtask

  // Advance the reference model with the currently driven inputs, then clock the DUT.
  task automatic tick();
    int  cnt, take, avail, eff;
    bit  rdy;
    cnt  = int'(fetch_count);
    take = int'(issue_take);
    rdy  = (8 - sb.size()) >= 2;
    if (flush) begin
      sb.delete();
    end else begin
`ifdef FETCH_QUEUE_BYPASS_EN
      if (sb.size() == 0) avail = cnt;
      else avail = (sb.size() < 2) ? sb.size() : 2;
`else
      avail = (sb.size() < 2) ? sb.size() : 2;
`endif
      eff = FREEZE ? 0 : ((take < avail) ? take : avail);
      if (rdy) begin
        for (int k = 0; k < cnt; k++) sb.push_back('{fetch_pc + 32'(4*k), mk(fetch_pc + 32'(4*k))});
      end
      repeat (eff) void'(sb.pop_front());
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
    checks++; if (issue_valid !== 2'b00) begin errors++; $display("FAIL reset_valid got %b exp 00", issue_valid); end
    checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", fetch_ready); end
    checks++; if (issue_pc !== 64'h0 || issue_instr !== 64'h0) begin errors++; $display("FAIL reset_data got pc %h instr %h exp 0", issue_pc, issue_instr); end
    @(negedge CLK); RESET = 1'b1;
    drive(2, 32'h100, 0, 0, 0); tick();
    drive(2, 32'h108, 0, 0, 0); tick();
    drive(1, 32'h110, 0, 0, 0); tick();
    checks++; if (occupancy !== 4'd5) begin errors++; $display("FAIL midfill_occ got %0d exp 5", occupancy); end
    #2; RESET = 1'b0; fetch_count = '0; #1;
    sb.delete();
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL async_reset_occ got %0d exp 0", occupancy); end
    checks++; if (issue_valid !== 2'b00) begin errors++; $display("FAIL async_reset_valid got %b exp 00", issue_valid); end
    checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL async_reset_ready got %b exp 1", fetch_ready); end
    @(negedge CLK); RESET = 1'b1;
  endtask

  task automatic test_fill();
    for (int k = 0; k < 5; k++) begin
      drive(2, 32'h400 + 32'(8*k), 0, 0, 0);
      tick();
      if (k == 2) begin
        checks++; if (occupancy !== 4'd6) begin errors++; $display("FAIL fill3_occ got %0d exp 6", occupancy); end
        checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL fill3_ready got %b exp 1", fetch_ready); end
      end
      if (k >= 3) begin
        checks++; if (occupancy !== 4'd8) begin errors++; $display("FAIL fill%0d_occ got %0d exp 8", k + 1, occupancy); end
        checks++; if (fetch_ready !== 1'b0) begin errors++; $display("FAIL fill%0d_ready got %b exp 0", k + 1, fetch_ready); end
      end
    end
    checks++; if (issue_valid !== 2'b11 || issue_pc !== {32'h404, 32'h400} || issue_instr !== {mk(32'h404), mk(32'h400)}) begin
      errors++; $display("FAIL fill_head got v %b pc %h instr %h exp v 11 pc 00000404_00000400", issue_valid, issue_pc, issue_instr);
    end
  endtask

  task automatic test_simultaneous();
    drive(2, 32'h500, 2, 0, 0);
    checks++; if (fetch_ready !== 1'b0) begin errors++; $display("FAIL simul_ready got %b exp 0", fetch_ready); end
    checks++; if (issue_pc !== {sb[1].pc, sb[0].pc}) begin errors++; $display("FAIL simul_pc1 got %h exp %h", issue_pc, {sb[1].pc, sb[0].pc}); end
    tick();
    checks++; if (occupancy !== 4'd6) begin errors++; $display("FAIL simul_drop_occ got %0d exp 6", occupancy); end
    drive(2, 32'h500, 2, 0, 0);
    checks++; if (issue_pc !== {32'h40C, 32'h408}) begin errors++; $display("FAIL simul_pc2 got %h exp 0000040c_00000408", issue_pc); end
    tick();
    checks++; if (occupancy !== 4'd6) begin errors++; $display("FAIL simul_hold_occ got %0d exp 6", occupancy); end
    for (int n = 0; n < 8 && sb.size() > 0; n++) begin
      drive(0, 32'h0, (sb.size() < 2) ? sb.size() : 2, 0, 0);
      for (int i = 0; i < 2; i++) begin
        checks++; if (issue_valid[i] !== (i < sb.size())) begin errors++; $display("FAIL drain_valid%0d got %b exp %b", i, issue_valid[i], i < sb.size()); end
        if (i < sb.size()) begin
          checks++;
          if (issue_pc[32*i +: 32] !== sb[i].pc || issue_instr[32*i +: 32] !== sb[i].instr) begin
            errors++; $display("FAIL drain_slot%0d got pc %h instr %h exp pc %h instr %h", i, issue_pc[32*i +: 32], issue_instr[32*i +: 32], sb[i].pc, sb[i].instr);
          end
        end
      end
      tick();
    end
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL drain_occ got %0d exp 0", occupancy); end
  endtask

  task automatic test_wrap();
    int pops = 0;
    for (int c = 0; c < 13; c++) begin
      drive((c < 12) ? 1 : 0, 32'h1000 + 32'(4*c), (sb.size() > 0) ? 1 : 0, 0, 0);
      if (sb.size() > 0) begin
        checks++;
        if (issue_valid[0] !== 1'b1 || issue_pc[31:0] !== 32'h1000 + 32'(4*pops) || issue_pc[31:0] !== sb[0].pc || issue_instr[31:0] !== sb[0].instr) begin
          errors++; $display("FAIL wrap_pop%0d got v %b pc %h instr %h exp pc %h", pops, issue_valid[0], issue_pc[31:0], issue_instr[31:0], 32'h1000 + 32'(4*pops));
        end
        pops++;
      end
      tick();
    end
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL wrap_end_occ got %0d exp 0", occupancy); end
  endtask

  task automatic test_flush();
    drive(2, 32'h2000, 0, 0, 0); tick();
    drive(2, 32'h2008, 0, 0, 0); tick();
    checks++; if (occupancy !== 4'd4) begin errors++; $display("FAIL flush_pre_occ got %0d exp 4", occupancy); end
    drive(2, 32'h2010, 1, 0, 1); tick();
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL flush_occ got %0d exp 0", occupancy); end
    checks++; if (issue_valid !== 2'b00) begin errors++; $display("FAIL flush_valid got %b exp 00", issue_valid); end
    checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %b exp 1", fetch_ready); end
  endtask

  task automatic test_freeze();
    drive(2, 32'h3000, 0, 0, 0); tick();
    drive(1, 32'h3008, 0, 0, 0); tick();
    checks++; if (occupancy !== 4'd3) begin errors++; $display("FAIL freeze_pre_occ got %0d exp 3", occupancy); end
    drive(0, 32'h0, 2, 1, 0); tick();
    checks++; if (occupancy !== 4'd3) begin errors++; $display("FAIL freeze_occ got %0d exp 3", occupancy); end
    checks++; if (issue_pc[31:0] !== 32'h3000) begin errors++; $display("FAIL freeze_head got %h exp 00003000", issue_pc[31:0]); end
    drive(2, 32'h300C, 2, 1, 0); tick();
    checks++; if (occupancy !== 4'd5) begin errors++; $display("FAIL freeze_push_occ got %0d exp 5", occupancy); end
    drive(0, 32'h0, 2, 1, 1); tick();
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL freeze_flush_occ got %0d exp 0", occupancy); end
  endtask

  task automatic test_bypass();
`ifdef FETCH_QUEUE_BYPASS_EN
    drive(2, 32'h200, 1, 0, 0);
    checks++; if (issue_valid !== 2'b11 || issue_pc[31:0] !== 32'h200 || issue_instr[31:0] !== mk(32'h200)) begin
      errors++; $display("FAIL bypass_same_cycle got v %b pc %h instr %h exp v 11 pc 00000200", issue_valid, issue_pc[31:0], issue_instr[31:0]);
    end
    tick();
    checks++; if (occupancy !== 4'd1) begin errors++; $display("FAIL bypass_occ got %0d exp 1", occupancy); end
    checks++; if (issue_pc[31:0] !== 32'h204) begin errors++; $display("FAIL bypass_rest got %h exp 00000204", issue_pc[31:0]); end
    drive(0, 32'h0, 1, 0, 0); tick();
`else
    drive(2, 32'h200, 0, 0, 0);
    checks++; if (issue_valid !== 2'b00) begin errors++; $display("FAIL nobypass_same_cycle got %b exp 00", issue_valid); end
    tick();
    checks++; if (issue_valid !== 2'b11 || issue_pc !== {32'h204, 32'h200}) begin
      errors++; $display("FAIL nobypass_next got v %b pc %h exp v 11 pc 00000204_00000200", issue_valid, issue_pc);
    end
    drive(0, 32'h0, 2, 0, 0); tick();
`endif
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL bypass_end_occ got %0d exp 0", occupancy); end
  endtask

  initial begin
    #2 RESET = 1'b0;
    #10;
    test_reset();
    test_fill();
    test_simultaneous();
    test_wrap();
    test_flush();
    test_freeze();
    test_bypass();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
